popcount_pipe: RTL and testbench
================================

Name: popcount_pipe

Overview:
- Pipelined, parametrised population-count engine that generalises the combinational 32-bit bit counter. Width is configurable, the adder tree is registered level by level, and it has a valid/ready stream interface.
- Adds an accumulate mode: popcounts of several beats are summed into a saturating burst total, emitted on the last beat.
- Sits between a data-stream producer and a statistics/threshold consumer.

Parameters:
- DATA_W, 32, input word width; power of two, 2..256.
- ACC_W, 16, output count/accumulator width; must be >= clog2(DATA_W+1).
- L (localparam), clog2(DATA_W), number of adder-tree levels.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  DATA_W  word to count.
- in_acc  input  1  per beat: 1 = accumulate this beat into the running burst total.
- in_last  input  1  per beat: closes the burst; forces emission.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_count  output  ACC_W  popcount, or burst total (saturated).
- out_sat  output  1  burst total saturated at 2^ACC_W-1.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_count=0, out_sat=0.
  - All stage valid bits=0, accumulator=0, sticky-sat=0.
  - in_ready=1 once rst is deasserted.
  - Asserting rst mid-operation discards all in-flight beats and any partial burst. The first beat after reset starts a fresh burst.
- Global enable: en = !out_valid | out_ready; in_ready = en (combinational). When en=0, every pipeline register holds. Bubbles are not compressed.
- Accept: a beat is taken when in_valid & in_ready. Its in_data, in_acc and in_last travel down the pipe together with a stage-valid bit.
- Tree:
  - Level k (1..L) adds adjacent pairs from level k-1. Level-k sums are k+1 bits wide.
  - Each level is registered. After L levels there is a single (L+1)-bit popcount.
- Output/accumulate stage (stage L+1):
  - Let sum = acc + pc, computed with one extra bit.
  - Saturate: if sum > 2^ACC_W-1, res = 2^ACC_W-1 and sat_now=1.
  - emit = in_last | !in_acc.
  - If emit: out_count<=res, out_sat<=sticky|sat_now, out_valid<=1, acc<=0, sticky<=0.
  - Else (accumulate, no emit): acc<=res, sticky<=sticky|sat_now. out_valid and out_count are unchanged, unless a handshake clears out_valid (see Handshake).
  - A beat with in_acc=0 and no open burst is a plain per-word count. Its out_count equals popcount(in_data).
  - A beat with in_acc=0 while a burst is open closes that burst, and its own count is included in the total.
- Latency: an accepted beat that emits has out_valid high L+1 cycles after acceptance, assuming no stall. With DATA_W=32 this is 6 cycles. Throughput is 1 beat/cycle.
- Handshake:
  - out_valid/out_count/out_sat are stable while out_valid & !out_ready.
  - When out_valid & out_ready and no new emitting beat reaches stage L+1, out_valid<=0 next cycle.
  - A simultaneous handshake and new emission loads the new result with no bubble.
- Boundary conditions:
  - all-zero word gives count 0.
  - all-ones word gives count DATA_W.
  - ACC_W = clog2(DATA_W+1) must compile. In that case a single word never saturates.
- in_valid low: no state change, apart from pipeline advance when en=1.

Test Plan:
- Reset then single beats (DATA_W=32, in_acc=0): 0x00000000, 0xFFFFFFFF, 0x80000001, 0xA5A5A5A5 -> out_count 0, 32, 2, 16; each appears 6 cycles after acceptance; out_sat=0.
- Back-to-back stream of 20 random words with out_ready=1 -> 20 results in order, one per cycle, matching a reference popcount.
- Burst, in_acc=1: 0xFFFFFFFF, 0x0000000F, then 0x00000003 with in_last=1 -> exactly one out_valid pulse, out_count=38. No output for the first two beats.
- Saturation (ACC_W=6, DATA_W=32): burst of 0xFFFFFFFF x3, last on 3rd -> out_count=63, out_sat=1. The next single beat 0x1 -> out_count=1, out_sat=0.
- Backpressure: hold out_ready=0 for 10 cycles during a stream -> in_ready=0 while out_valid=1; out_count is stable. Release -> no loss or duplication, order preserved.
- Async reset asserted mid-burst (2 acc beats accepted) and between clock edges -> outputs 0 immediately. A post-reset single beat 0x7 -> out_count=3 (old partial sum discarded).

Source files
------------

// File: rtl/popcount_pipe.sv
// Pipelined popcount engine: a registered pairwise adder tree feeding a
// saturating burst accumulator, with valid/ready on both sides.
module popcount_pipe #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_acc,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic              out_sat
);
    localparam int L = $clog2(DATA_W);

    // Handshake contract: a beat moves on either port only in a cycle where
    // valid & ready are both high; out_* hold while out_valid & !out_ready,
    // and the whole pipe freezes together (no bubble squeezing).
    logic en;
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // Level k holds DATA_W>>k partial sums of k+1 bits; level 0 is the raw input.
    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int N = DATA_W >> k;
        localparam int W = k + 1;
        logic [N*W-1:0] s;
        logic           v;
        logic           a;
        logic           l;
        if (k == 0) begin : g_in
            assign s = in_data;
            assign v = in_valid;
            assign a = in_acc;
            assign l = in_last;
        end else begin : g_add
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s <= '0;
                    v <= 1'b0;
                    a <= 1'b0;
                    l <= 1'b0;
                end else if (en) begin
                    for (int i = 0; i < N; i++) begin
                        s[i*W +: W] <= (W)'(g_lvl[k-1].s[(2*i)*(W-1) +: W-1])
                                     + (W)'(g_lvl[k-1].s[(2*i+1)*(W-1) +: W-1]);
                    end
                    v <= g_lvl[k-1].v;
                    a <= g_lvl[k-1].a;
                    l <= g_lvl[k-1].l;
                end
            end
        end
    end

    logic [ACC_W-1:0] acc;
    logic             sticky;
    logic [ACC_W:0]   pc_ext;
    logic [ACC_W:0]   sum;
    logic             sat_now;
    logic [ACC_W-1:0] res;
    logic             emit;

    // acc <= 2^ACC_W-1 and pc <= DATA_W < 2^ACC_W, so overflow shows only in the top bit.
    always_comb begin
        pc_ext  = (ACC_W+1)'(g_lvl[L].s);
        sum     = {1'b0, acc} + pc_ext;
        sat_now = sum[ACC_W];
        res     = sat_now ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        emit    = g_lvl[L].v & (g_lvl[L].l | !g_lvl[L].a);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= 1'b0;
            acc       <= '0;
            sticky    <= 1'b0;
        end else if (en) begin
            // With en high the current result is either absent or being taken.
            out_valid <= emit;
            if (emit) begin
                out_count <= res;
                out_sat   <= sticky | sat_now;
                acc       <= '0;
                sticky    <= 1'b0;
            end else if (g_lvl[L].v) begin
                acc    <= res;
                sticky <= sticky | sat_now;
            end
        end
    end
endmodule

// File: tb/tb_popcount_pipe.sv
// Scoreboard bench for popcount_pipe: accepted beats feed a burst-total model
// whose results are queued and popped by an independent output monitor.
module tb_popcount_pipe;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 6;
    localparam int L      = 5;
    localparam int MAXV   = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_acc = 1'b0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_count;
    logic              out_sat;

    popcount_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Scoreboard: {sat, count} per emitted result plus optional latency check.
    logic [ACC_W:0] exp_q[$];
    int             acc_cyc_q[$];
    bit             lat_q[$];
    bit             lat_mode = 1'b0;
    int             m_total  = 0;
    bit             m_sticky = 1'b0;

    function automatic int popcount(input logic [DATA_W-1:0] d);
        int c = 0;
        for (int i = 0; i < DATA_W; i++) c += int'(d[i]);
        return c;
    endfunction

    int tot;
    bit sat;
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            tot = m_total + popcount(in_data);
            sat = m_sticky || (tot > MAXV);
            if (tot > MAXV) tot = MAXV;
            if (in_last || !in_acc) begin
                exp_q.push_back({sat, tot[ACC_W-1:0]});
                acc_cyc_q.push_back(cyc);
                lat_q.push_back(lat_mode);
                m_total  = 0;
                m_sticky = 1'b0;
            end else begin
                m_total  = tot;
                m_sticky = sat;
            end
        end
    end

    logic [ACC_W:0] exp_v;
    int             exp_c;
    bit             exp_l;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                fail_timeout("unexpected_output");
            end else begin
                exp_v = exp_q.pop_front();
                exp_c = acc_cyc_q.pop_front();
                exp_l = lat_q.pop_front();
                check("out_count", out_count, exp_v[ACC_W-1:0]);
                check("out_sat", out_sat, exp_v[ACC_W]);
                if (exp_l) check("latency", cyc - exp_c, L + 1);
            end
        end
    end

    // Stall behaviour: input blocked and output frozen while the result waits.
    bit               stalled = 1'b0;
    logic [ACC_W-1:0] held_count;
    logic             held_sat;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_hold", out_valid, 1);
                check("stall_count_hold", out_count, held_count);
                check("stall_sat_hold", out_sat, held_sat);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                stalled    = 1'b1;
                held_count = out_count;
                held_sat   = out_sat;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Drivers run at posedge+1 so DUT outputs settle before the negedge samplers.
    task automatic send(input logic [DATA_W-1:0] d, input logic a, input logic l);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_acc   = a;
        in_last  = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) fail_timeout("send_accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            idle(1);
            i++;
        end
        if (exp_q.size() != 0) fail_timeout("drain");
        idle(2);
    endtask

    logic [DATA_W-1:0] singles[4];

    initial begin
        singles[0] = 32'h0000_0000;
        singles[1] = 32'hFFFF_FFFF;
        singles[2] = 32'h8000_0001;
        singles[3] = 32'hA5A5_A5A5;

        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_count", out_count, 0);
        check("reset_out_sat", out_sat, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);

        // Isolated single words with latency checking.
        lat_mode = 1'b1;
        foreach (singles[i]) begin
            send(singles[i], 1'b0, 1'b0);
            idle(8);
        end
        drain();
        lat_mode = 1'b0;

        // Back-to-back random words.
        for (int i = 0; i < 20; i++) send($urandom, 1'b0, 1'b0);
        drain();

        // Burst 32 + 4 + 2.
        send(32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h0000_000F, 1'b1, 1'b0);
        send(32'h0000_0003, 1'b1, 1'b1);
        drain();

        // Saturating burst, then a fresh single word.
        send(32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 1'b1);
        send(32'h0000_0001, 1'b0, 1'b0);
        drain();

        // Backpressure window during a stream.
        fork
            for (int i = 0; i < 16; i++) send($urandom, 1'b0, 1'b0);
            begin
                idle(8);
                out_ready = 1'b0;
                idle(10);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random mix of bursts and singles with random backpressure.
        fork
            for (int i = 0; i < 40; i++)
                send($urandom & ((32'h1 << $urandom_range(31, 1)) - 1),
                     1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
            for (int i = 0; i < 60; i++) begin
                out_ready = ($urandom_range(3, 0) != 0);
                idle(1);
            end
        join
        out_ready = 1'b1;
        send(32'h0, 1'b0, 1'b1);
        drain();

        // Async reset mid-burst while a stalled result is showing.
        out_ready = 1'b0;
        send(32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0003, 1'b1, 1'b0);
        send(32'h0000_0005, 1'b1, 1'b0);
        idle(8);
        check("pre_reset_out_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_count", out_count, 0);
        check("async_rst_out_sat", out_sat, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        lat_q.delete();
        m_total  = 0;
        m_sticky = 1'b0;
        out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        send(32'h0000_0007, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
